calc_seq: RTL and testbench
===========================

# calc_seq

Key-entry sequencer for the six-digit BCD calculator datapath. It assembles operand A, the operator and operand B from single-cycle key strobes, then drives the 55-bit packed request word into the combinational calculator. It captures the calculator's result and error flags in a one-cycle evaluate step and drives a six-digit display word. It sits between the keypad decoder and the calculator, and is the only writer of the calculator input.

## Interface
Parameters:
- NDIG, 6, digits per operand (fixed by the datapath; other values unsupported)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0..9 digit, A div, B mul, C sub, D add, E equals, F clear
- calc_word  out  55  [54] ovf_in, [53] inf_in, [52] flag_in, [51:48] op, [47:24] A digits, [23:0] B digits
- calc_result  in  24  calculator result digits; leading blanks are 4'hF
- calc_flag  in  1  calculator flag_out
- calc_inf  in  1  calculator flag_inf_out
- calc_ovf  in  1  calculator flag_ovf_out
- disp  out  24  six display digits, 4'hF = blank
- busy  out  1  high in EVAL; keys ignored
- err  out  1  high in ERROR state
- err_kind  out  1  0 = overflow, 1 = divide-by-zero; valid while err

## Operation
- Digit encoding: 4'hF is blank (value 0). Operand registers reset to all-blank.
- calc_word[54:52] are always driven 0. The calculator therefore reports an error as calc_inf=1 or calc_ovf=1; calc_flag=1 means the result is valid.
- Digit entry shifts the register left one digit; the new digit enters at [3:0]. Once NDIG digits are held, further digits are dropped and the register is unchanged.
- FSM states: ENTER_A, ENTER_OP, ENTER_B, EVAL, RESULT, ERROR. Reset state is ENTER_A.
- ENTER_A:
  - digit: shift into A.
  - operator: latch op and go to ENTER_OP. If A is all-blank, A is used as value 0.
  - E: no effect.
- ENTER_OP:
  - operator: replace op.
  - digit: B is cleared, the digit is shifted in, go to ENTER_B.
  - E: no effect.
- ENTER_B:
  - digit: shift into B.
  - operator: replace op, B is unchanged.
  - E: go to EVAL.
- EVAL (exactly one cycle):
  - calc_word is already stable.
  - Sample calc_result/calc_inf/calc_ovf.
  - If calc_inf: go to ERROR with err_kind=1.
  - Else if calc_ovf: go to ERROR with err_kind=0.
  - Else: A <= calc_result, go to RESULT.
- RESULT:
  - operator: latch op, go to ENTER_OP (chaining uses the result as A).
  - digit: A cleared, digit shifted in, go to ENTER_A.
  - E: re-enter EVAL with the same op and B (repeat-equals).
- ERROR:
  - digit or operator: ignored.
  - F (clear): the only exit.
- F in any non-EVAL state: A, B and op cleared to blank/4'h0, err cleared, go to ENTER_A.
- disp:
  - A in ENTER_A, ENTER_OP and RESULT.
  - B in ENTER_B.
  - A in EVAL.
  - 24'hFFFFFF in ERROR.
- Subtraction with A<B returns as calculator overflow and is handled as an ERROR with err_kind=0.
- Idle op field is 4'h0, for which the calculator returns 0.

## Timing
- Reset values:
  - state ENTER_A
  - A = B = 24'hFFFFFF, op = 4'h0
  - calc_word = {3'b000, 4'h0, 24'hFFFFFF, 24'hFFFFFF}
  - disp = 24'hFFFFFF
  - busy = 0, err = 0, err_kind = 0
- Key latency: a key accepted at edge N updates registers and disp at edge N; the new values are visible after edge N.
- E in ENTER_B at edge N:
  - EVAL is active during cycle N..N+1 and busy=1.
  - The result is captured at edge N+1.
  - RESULT or ERROR is visible after N+1.
- A key_valid while busy=1 is dropped, including F; it is not queued.
- Reset asserted mid-EVAL wins over capture; all registers take their reset values.
- key_valid held high for consecutive cycles counts as one key per cycle.

## Structure
- Package calc_pkg holds:
  - key code constants: KEY_DIV=4'hA, KEY_MUL=4'hB, KEY_SUB=4'hC, KEY_ADD=4'hD, KEY_EQ=4'hE, KEY_CLR=4'hF
  - BLANK=4'hF
  - state enum
  - calc_word field offsets
- Sub-module calc_digit_reg: NDIG-digit BCD entry shift register with clear, shift-in and parallel-load. A and B are two instances of it.
- Top: FSM, calc_word assembly and result capture.

## Test plan
- Reset, then keys 1,2,D,3,4,E -> after EVAL disp=24'hFFFF46, err=0, state RESULT.
- Keys 7,A,0,E -> disp=24'hFFFFFF, err=1, err_kind=1; then F -> disp=24'hFFFFFF, err=0, state ENTER_A.
- Keys 9,9,9,9,9,9,9 (seven digits) -> disp=24'h999999 (seventh dropped); then B,2,E -> err=1, err_kind=0.
- Chain: 5,B,4,E, then C,6,E -> first disp=24'hFFFF20, then disp=24'hFFFF14; then E again -> disp=24'hFFFFF8 (repeat-equals).
- Keys 3,C,8,E -> err=1, err_kind=0 (negative result); any key pulse during the EVAL cycle -> state unchanged by that key.
- rst_n low during EVAL cycle -> all outputs at reset values on the next cycle, no capture.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, sequencer states and calc_word field layout for the
// BCD calculator key-entry path.
package calc_pkg;

  localparam int CALC_NDIG = 6;

  localparam logic [3:0] KEY_DIV = 4'hA;
  localparam logic [3:0] KEY_MUL = 4'hB;
  localparam logic [3:0] KEY_SUB = 4'hC;
  localparam logic [3:0] KEY_ADD = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;
  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] OP_IDLE = 4'h0;

  // calc_word field offsets
  localparam int CW_W     = 55;
  localparam int CW_OVF   = 54;
  localparam int CW_INF   = 53;
  localparam int CW_FLAG  = 52;
  localparam int CW_OP_LSB = 48;
  localparam int CW_A_LSB = 24;
  localparam int CW_B_LSB = 0;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_OP,
    ST_ENTER_B,
    ST_EVAL,
    ST_RESULT,
    ST_ERROR
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_oper(input logic [3:0] k);
    return (k >= KEY_DIV) && (k <= KEY_ADD);
  endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Keypad, calculator and display signals of the key-entry sequencer.
// master = sequencer side, slave = keypad/calculator/display side.
interface calc_seq_if;
  import calc_pkg::*;

  logic                      key_valid;
  logic [3:0]                key_code;
  logic [CW_W-1:0]           calc_word;
  logic [4*CALC_NDIG-1:0]    calc_result;
  logic                      calc_flag;
  logic                      calc_inf;
  logic                      calc_ovf;
  logic [4*CALC_NDIG-1:0]    disp;
  logic                      busy;
  logic                      err;
  logic                      err_kind;

  modport master (
    input  key_valid, key_code, calc_result, calc_flag, calc_inf, calc_ovf,
    output calc_word, disp, busy, err, err_kind
  );

  modport slave (
    output key_valid, key_code, calc_result, calc_flag, calc_inf, calc_ovf,
    input  calc_word, disp, busy, err, err_kind
  );

endinterface

// File: rtl/calc_digit_reg.sv
// BCD entry shift register: clear, shift-in at the low digit, parallel load.
// Latency: one clock from control to q. No backpressure; full register drops digits.
module calc_digit_reg
  import calc_pkg::*;
#(
  parameter int NDIG = CALC_NDIG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [3:0]        din,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_dat,
  output logic [4*NDIG-1:0] q
);

  logic [4*NDIG-1:0] q_q;
  logic [4*NDIG-1:0] q_d;
  logic [4*NDIG-1:0] base;

  // Clear applies first so clear+shift yields a fresh one-digit entry.
  always_comb begin
    base = clr ? {NDIG{BLANK}} : q_q;
    q_d  = base;
    if (load) begin
      q_d = load_dat;
    end else if (shift && (base[4*NDIG-1 -: 4] == BLANK)) begin
      q_d = {base[4*NDIG-5:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= {NDIG{BLANK}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/calc_seq.sv
// Key-entry sequencer: builds A/op/B for the BCD calculator, captures its result.
// Latency: keys act at the accepting edge; EVAL is one cycle. Keys are dropped while busy.
module calc_seq
  import calc_pkg::*;
#(
  parameter int NDIG = CALC_NDIG
) (
  input  logic      clk,
  input  logic      rst_n,
  calc_seq_if.master bus
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        err_kind_q, err_kind_d;

  logic [4*NDIG-1:0] a_q, b_q;
  logic a_clr, a_shift, a_load;
  logic b_clr, b_shift;
  logic k_dig, k_op, k_eq, k_clr;

  calc_digit_reg #(.NDIG(NDIG)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (a_clr),
    .shift    (a_shift),
    .din      (bus.key_code),
    .load     (a_load),
    .load_dat (bus.calc_result),
    .q        (a_q)
  );

  calc_digit_reg #(.NDIG(NDIG)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (b_clr),
    .shift    (b_shift),
    .din      (bus.key_code),
    .load     (1'b0),
    .load_dat ({NDIG{BLANK}}),
    .q        (b_q)
  );

  always_comb begin
    k_dig = bus.key_valid && is_digit(bus.key_code);
    k_op  = bus.key_valid && is_oper(bus.key_code);
    k_eq  = bus.key_valid && (bus.key_code == KEY_EQ);
    k_clr = bus.key_valid && (bus.key_code == KEY_CLR);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_kind_d = err_kind_q;
    a_clr      = 1'b0;
    a_shift    = 1'b0;
    a_load     = 1'b0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;

    if (state_q == ST_EVAL) begin
      // Keys arriving here are dropped, clear included.
      if (bus.calc_inf) begin
        err_kind_d = 1'b1;
        state_d    = ST_ERROR;
      end else if (bus.calc_ovf) begin
        err_kind_d = 1'b0;
        state_d    = ST_ERROR;
      end else begin
        a_load  = 1'b1;
        state_d = ST_RESULT;
      end
    end else if (k_clr) begin
      a_clr      = 1'b1;
      b_clr      = 1'b1;
      op_d       = OP_IDLE;
      err_kind_d = 1'b0;
      state_d    = ST_ENTER_A;
    end else begin
      unique case (state_q)
        ST_ENTER_A: begin
          if (k_dig) begin
            a_shift = 1'b1;
          end else if (k_op) begin
            op_d    = bus.key_code;
            state_d = ST_ENTER_OP;
          end
        end
        ST_ENTER_OP: begin
          if (k_op) begin
            op_d = bus.key_code;
          end else if (k_dig) begin
            b_clr   = 1'b1;
            b_shift = 1'b1;
            state_d = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (k_dig) begin
            b_shift = 1'b1;
          end else if (k_op) begin
            op_d = bus.key_code;
          end else if (k_eq) begin
            state_d = ST_EVAL;
          end
        end
        ST_RESULT: begin
          if (k_op) begin
            op_d    = bus.key_code;
            state_d = ST_ENTER_OP;
          end else if (k_dig) begin
            a_clr   = 1'b1;
            a_shift = 1'b1;
            state_d = ST_ENTER_A;
          end else if (k_eq) begin
            state_d = ST_EVAL;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ENTER_A;
      op_q       <= OP_IDLE;
      err_kind_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_kind_q <= err_kind_d;
    end
  end

  always_comb begin
    bus.calc_word                    = '0;
    bus.calc_word[CW_OP_LSB +: 4]    = op_q;
    bus.calc_word[CW_A_LSB +: 4*NDIG] = a_q;
    bus.calc_word[CW_B_LSB +: 4*NDIG] = b_q;

    unique case (state_q)
      ST_ENTER_B: bus.disp = b_q;
      ST_ERROR:   bus.disp = {NDIG{BLANK}};
      default:    bus.disp = a_q;
    endcase

    bus.busy     = (state_q == ST_EVAL);
    bus.err      = (state_q == ST_ERROR);
    bus.err_kind = err_kind_q;
  end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: behavioural BCD calculator on calc_word, scoreboard of
// expected display/error state checked when each evaluation completes.
module tb_calc_seq;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_seq_if bus();

  calc_seq #(.NDIG(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    string       tag;
    logic [23:0] disp;
    logic        err;
    logic        err_kind;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [54:0] CW_RST = {3'b000, 4'h0, 24'hFFFFFF, 24'hFFFFFF};

  function automatic longint unsigned bcd_dec(input logic [23:0] w);
    longint unsigned v;
    logic [3:0] d;
    v = 0;
    for (int i = 5; i >= 0; i--) begin
      d = w[i*4 +: 4];
      v = v * 10 + ((d == 4'hF) ? 0 : longint'(d));
    end
    return v;
  endfunction

  function automatic logic [23:0] bcd_enc(input longint unsigned v);
    logic [23:0] r;
    longint unsigned t;
    r = '1;
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || t != 0) begin
        r[i*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  // Reference calculator driven from calc_word.
  longint unsigned ma, mb, mr;
  logic m_inf, m_ovf;
  always_comb begin
    ma    = bcd_dec(bus.calc_word[47:24]);
    mb    = bcd_dec(bus.calc_word[23:0]);
    mr    = 0;
    m_inf = 1'b0;
    m_ovf = 1'b0;
    case (bus.calc_word[51:48])
      KEY_DIV: if (mb == 0) m_inf = 1'b1; else mr = ma / mb;
      KEY_MUL: mr = ma * mb;
      KEY_SUB: if (ma < mb) m_ovf = 1'b1; else mr = ma - mb;
      KEY_ADD: mr = ma + mb;
      default: mr = 0;
    endcase
    if (mr > 999999) m_ovf = 1'b1;
    bus.calc_result = (m_inf || m_ovf) ? 24'hFFFFFF : bcd_enc(mr);
    bus.calc_inf    = m_inf;
    bus.calc_ovf    = m_ovf;
    bus.calc_flag   = !(m_inf || m_ovf);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  function automatic logic [3:0] ch2k(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
    return 4'(c - 8'h41 + 10);
  endfunction

  task automatic type_keys(input string s);
    for (int i = 0; i < s.len(); i++) key(ch2k(s[i]));
  endtask

  // Press E (optionally a second key during EVAL), then check the outcome.
  task automatic eval(input string tag, input logic [23:0] d, input logic e,
                      input logic ek, input logic poke, input logic [3:0] pk);
    exp_t x;
    int   cnt;
    x.tag = tag; x.disp = d; x.err = e; x.err_kind = ek;
    sb.push_back(x);
    key(KEY_EQ);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    if (poke) key(pk);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, ".done"}, 64'(bus.busy), 64'd0);
    x = sb.pop_front();
    chk({x.tag, ".disp"}, 64'(bus.disp), 64'(x.disp));
    chk({x.tag, ".err"}, 64'(bus.err), 64'(x.err));
    if (x.err) chk({x.tag, ".kind"}, 64'(bus.err_kind), 64'(x.err_kind));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".disp"}, 64'(bus.disp), 64'hFFFFFF);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".err"}, 64'(bus.err), 64'd0);
    chk({tag, ".kind"}, 64'(bus.err_kind), 64'd0);
    chk({tag, ".word"}, 64'(bus.calc_word), 64'(CW_RST));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("idle");

    // 12 + 34
    type_keys("12");
    chk("a12", 64'(bus.disp), 64'hFFFF12);
    type_keys("D");
    chk("op_disp", 64'(bus.disp), 64'hFFFF12);
    type_keys("34");
    chk("b34", 64'(bus.disp), 64'hFFFF34);
    chk("word", 64'(bus.calc_word), 64'({3'b000, KEY_ADD, 24'hFFFF12, 24'hFFFF34}));
    eval("add", 24'hFFFF46, 1'b0, 1'b0, 1'b0, 4'h0);

    // divide by zero, keys ignored in ERROR, clear exits
    type_keys("7A0");
    eval("div0", 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 4'h0);
    type_keys("5B");
    chk("err_hold", 64'(bus.err), 64'd1);
    chk("err_disp", 64'(bus.disp), 64'hFFFFFF);
    key(KEY_CLR);
    chk("clr.err", 64'(bus.err), 64'd0);
    chk("clr.disp", 64'(bus.disp), 64'hFFFFFF);
    chk("clr.kind", 64'(bus.err_kind), 64'd0);
    type_keys("8");
    chk("after_clr", 64'(bus.disp), 64'hFFFFF8);
    key(KEY_CLR);

    // seventh digit dropped, then multiply overflow
    type_keys("9999999");
    chk("full", 64'(bus.disp), 64'h999999);
    type_keys("B2");
    eval("mulovf", 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 4'h0);
    key(KEY_CLR);

    // chaining and repeat-equals
    type_keys("5B4");
    eval("mul", 24'hFFFF20, 1'b0, 1'b0, 1'b0, 4'h0);
    type_keys("C6");
    eval("chain", 24'hFFFF14, 1'b0, 1'b0, 1'b0, 4'h0);
    eval("repeq", 24'hFFFFF8, 1'b0, 1'b0, 1'b0, 4'h0);
    key(KEY_CLR);

    // negative result, with a clear pressed during EVAL (must be dropped)
    type_keys("3C8");
    eval("neg", 24'hFFFFFF, 1'b1, 1'b0, 1'b1, KEY_CLR);
    key(KEY_CLR);

    // blank A counts as zero; operator replaced in ENTER_OP and ENTER_B
    type_keys("D5");
    eval("blankA", 24'hFFFFF5, 1'b0, 1'b0, 1'b0, 4'h0);
    key(KEY_CLR);
    type_keys("2DB3");
    eval("oprep", 24'hFFFFF6, 1'b0, 1'b0, 1'b0, 4'h0);
    key(KEY_CLR);
    type_keys("9D4A");
    eval("oprepB", 24'hFFFFF2, 1'b0, 1'b0, 1'b0, 4'h0);
    key(KEY_CLR);

    // reset during EVAL beats capture
    type_keys("1D1");
    key(KEY_EQ);
    chk("rst_eval.busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_eval");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
